imem_sync_rom: RTL and testbench

- Parametrised, synchronous instruction memory for the pipelined CPU's IF stage.
- Replaces the combinational 64-word ROM with a registered-read array, a fetch request/response handshake, stall/flush support, a boot-load write port and fault flagging.
- Sits between the PC register and the IF/ID pipeline register; the response register *is* the IF/ID instruction source.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_array.sv | 32 +++
 rtl/imem_sync_rom.sv | 113 +++++++++++
 tb/tb_imem_sync_rom.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and helpers for the synchronous instruction memory.
package imem_pkg;

  // Instruction returned for faults, flushes, bubbles and reset.
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  // Default field widths of a fetch response.
  localparam int unsigned IMEM_ADDR_W = 32;
  localparam int unsigned IMEM_DATA_W = 32;

  // Fetch response fields at the default widths.
  typedef struct packed {
    logic                   valid;
    logic                   fault;
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] inst;
  } imem_resp_t;

  // A fetch faults if it is not word aligned or if any bit above the word index is set.
  function automatic logic imem_addr_fault(input logic [63:0] addr, input int unsigned idx_w);
    return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 64'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W synchronous RAM: one write port, one registered read port, write-first.
// Contents are not reset; they are loaded through the boot write port.
module imem_array #(
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port, and read register that only updates on i_re so a held response stays put.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_sync_rom.sv
// Registered-read instruction memory for the IF stage: fetch handshake, stall hold,
// flush/redirect, fault flagging, boot-load port and accepted-fetch counter.
module imem_sync_rom
  import imem_pkg::*;
#(
  parameter  int unsigned        ADDR_W   = 32,
  parameter  int unsigned        DATA_W   = 32,
  parameter  int unsigned        DEPTH    = 64,
  parameter  logic [DATA_W-1:0]  NOP_WORD = DATA_W'(IMEM_NOP_WORD),
  localparam int unsigned        IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_fault,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [31:0]       fetch_cnt
);

  // Response register; r_sel marks a response whose word comes from the array
  // (and therefore was counted in fetch_cnt).
  logic              r_valid, r_valid_d;
  logic              r_fault, r_fault_d;
  logic              r_sel,   r_sel_d;
  logic [ADDR_W-1:0] r_addr,  r_addr_d;
  logic [31:0]       r_cnt,   r_cnt_d;

  logic              w_hold;
  logic              w_accept;
  logic              w_fault;
  logic              w_rd_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_hold    = stall && r_valid && !flush;
  assign req_ready = rst_n && !w_hold;
  assign w_accept  = req_valid && req_ready;
  assign w_fault   = imem_addr_fault(64'(req_addr), IDX_W);
  assign w_rd_en   = w_accept && !w_fault;
  assign w_idx     = req_addr[IDX_W+1:2];

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (prog_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (w_rd_en),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // Next response: load on accept, keep while held, otherwise empty the slot (bubble/flush).
  always_comb begin
    r_valid_d = 1'b0;
    r_fault_d = 1'b0;
    r_sel_d   = 1'b0;
    r_addr_d  = r_addr;
    r_cnt_d   = r_cnt;
    if (w_accept) begin
      r_valid_d = 1'b1;
      r_fault_d = w_fault;
      r_sel_d   = !w_fault;
      r_addr_d  = req_addr;
    end else if (w_hold) begin
      r_valid_d = r_valid;
      r_fault_d = r_fault;
      r_sel_d   = r_sel;
    end
    // A counted response killed by flush is taken back; a redirect may count in the same cycle.
    if (w_rd_en) begin
      r_cnt_d = r_cnt_d + 32'd1;
    end
    if (flush && r_valid && r_sel) begin
      r_cnt_d = r_cnt_d - 32'd1;
    end
  end

  // State update with synchronous active-low reset; array contents are untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= r_valid_d;
      r_fault <= r_fault_d;
      r_sel   <= r_sel_d;
      r_addr  <= r_addr_d;
      r_cnt   <= r_cnt_d;
    end
  end

  assign resp_valid = r_valid;
  assign resp_fault = r_fault;
  assign resp_addr  = r_addr;
  assign resp_inst  = r_sel ? w_rdata : NOP_WORD;
  assign fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_imem_sync_rom.sv
// Directed bench for imem_sync_rom with hand-computed expectations.
module tb_imem_sync_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        stall;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        resp_fault;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] W0 = 32'h0010_0443;
  localparam logic [31:0] W1 = 32'h0020_1025;
  localparam logic [31:0] W2 = 32'h0410_18E1;
  localparam logic [31:0] W3 = 32'h0420_2021;

  always #5 clk = ~clk;

  imem_sync_rom u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .stall      (stall),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_addr  (resp_addr),
    .resp_fault (resp_fault),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input string tag, input logic v, input logic [31:0] inst,
                      input logic [31:0] addr, input logic f);
    check({tag, ".valid"}, resp_valid, v);
    check({tag, ".inst"},  resp_inst,  inst);
    check({tag, ".addr"},  resp_addr,  addr);
    check({tag, ".fault"}, resp_fault, f);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick();
    tick();
    resp("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset.cnt", fetch_cnt, 0);
    check("reset.ready", req_ready, 0);
    rst_n = 1'b1;

    // Boot-load three words.
    prog_we = 1'b1;
    prog_addr = 6'd0; prog_data = W0; tick();
    prog_addr = 6'd1; prog_data = W1; tick();
    prog_addr = 6'd2; prog_data = W2; tick();
    prog_we = 1'b0;

    // Back-to-back stream.
    req_valid = 1'b1;
    req_addr = 32'd0; tick(); resp("s0", 1'b1, W0, 32'd0, 1'b0);
    req_addr = 32'd4; tick(); resp("s1", 1'b1, W1, 32'd4, 1'b0);
    req_addr = 32'd8; tick(); resp("s2", 1'b1, W2, 32'd8, 1'b0);
    check("stream.cnt", fetch_cnt, 3);
    req_valid = 1'b0;
    tick();
    resp("bubble", 1'b0, 32'h0, 32'd8, 1'b0);

    // Stall hold.
    req_valid = 1'b1; req_addr = 32'd4; tick();
    resp("h0", 1'b1, W1, 32'd4, 1'b0);
    req_addr = 32'd8; stall = 1'b1; #1;
    check("hold.ready0", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.inst", resp_inst, W1);
      check("hold.addr", resp_addr, 32'd4);
      check("hold.ready", req_ready, 0);
    end
    check("hold.cnt", fetch_cnt, 4);
    stall = 1'b0; #1;
    check("hold.ready_rel", req_ready, 1);
    tick();
    resp("h1", 1'b1, W2, 32'd8, 1'b0);
    check("h1.cnt", fetch_cnt, 5);

    // Flush with redirect.
    req_addr = 32'd8; tick();
    check("f0.cnt", fetch_cnt, 6);
    flush = 1'b1; req_addr = 32'd0; tick();
    resp("f1", 1'b1, W0, 32'd0, 1'b0);
    check("f1.cnt", fetch_cnt, 6);
    // Flush with no request while stalled empties the slot and uncounts it.
    req_valid = 1'b0; stall = 1'b1; #1;
    check("f2.ready", req_ready, 1);
    tick();
    check("f2.valid", resp_valid, 0);
    check("f2.inst", resp_inst, 32'h0);
    check("f2.cnt", fetch_cnt, 5);
    flush = 1'b0; stall = 1'b0;

    // Faults.
    req_valid = 1'b1; req_addr = 32'd6; tick();
    resp("mis", 1'b1, 32'h0, 32'd6, 1'b1);
    req_addr = 32'd256; tick();
    resp("oor", 1'b1, 32'h0, 32'd256, 1'b1);
    check("fault.cnt", fetch_cnt, 5);

    // Write-first collision.
    prog_we = 1'b1; prog_addr = 6'd3; prog_data = W3; req_addr = 32'd12; tick();
    prog_we = 1'b0;
    resp("wf", 1'b1, W3, 32'd12, 1'b0);
    check("wf.cnt", fetch_cnt, 6);

    // Reset during a held response.
    req_addr = 32'd4; tick();
    stall = 1'b1; req_addr = 32'd8; tick();
    check("pre_rst.inst", resp_inst, W1);
    rst_n = 1'b0; tick();
    resp("rst", 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst.cnt", fetch_cnt, 0);
    rst_n = 1'b1; stall = 1'b0;
    req_addr = 32'd12; tick(); resp("post0", 1'b1, W3, 32'd12, 1'b0);
    req_addr = 32'd0;  tick(); resp("post1", 1'b1, W0, 32'd0, 1'b0);
    check("post.cnt", fetch_cnt, 2);
    req_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
